// File: rtl/zov5640_sccb_slave.sv
// rtl/zov5640_sccb_slave.sv - SCCB target with 16-bit sub-address, 8-bit data and register strobe port
// Decodes start/stop/ID/sub-address/data on synchronised SCL/SDA; drives ACK and read bits open-drain.
module zov5640_sccb_slave #(
  parameter logic [6:0] SLAVE_ID = 7'h3C,
  parameter int         SYNC_STG = 2
) (
  input  logic        iClk,
  input  logic        iRstN,
  input  logic        iEn,
  input  logic        iSCL,
  input  logic        iSDA,
  output logic        oSDA_OE,
  output logic [15:0] oRegAddr,
  output logic        oRegWrEn,
  output logic [7:0]  oRegWrData,
  output logic        oRegRdEn,
  input  logic [7:0]  iRegRdData,
  output logic        oBusy
);

  typedef enum logic [3:0] {
    S_IDLE, S_DEV_ADDR, S_ACK_DEV, S_SUB_HI, S_ACK_HI, S_SUB_LO, S_ACK_LO,
    S_WR_DATA, S_ACK_WR, S_RD_DATA, S_RD_MACK, S_IGNORE
  } state_t;

  logic [SYNC_STG-1:0] scl_sync, sda_sync;
  logic                scl_prev, sda_prev;
  logic                scl, sda;
  logic                scl_rise, scl_fall, start_det, stop_det;

  state_t      state, state_n;
  logic [3:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  shreg, shreg_n;
  logic [7:0]  shift_in;
  logic        rw, rw_n;
  logic [15:0] addr, addr_n;
  logic        oe, oe_n;
  logic        busy, busy_n;
  logic        wr_en, wr_en_n;
  logic [7:0]  wr_data, wr_data_n;
  logic        rd_en, rd_en_n;
  logic        rd_cap, rd_cap_n;
  logic        rd_wait, rd_wait_n;

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STG-2:0], iSCL};
      sda_sync <= {sda_sync[SYNC_STG-2:0], iSDA};
      scl_prev <= scl;
      sda_prev <= sda;
    end
  end

  assign scl       = scl_sync[SYNC_STG-1];
  assign sda       = sda_sync[SYNC_STG-1];
  assign scl_rise  = ~scl_prev & scl;
  assign scl_fall  = scl_prev & ~scl;
  assign start_det = scl & scl_prev & sda_prev & ~sda;
  assign stop_det  = scl & scl_prev & ~sda_prev & sda;
  assign shift_in  = {shreg[6:0], sda};

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      state   <= S_IDLE;
      bit_cnt <= 4'd0;
      shreg   <= 8'd0;
      rw      <= 1'b0;
      addr    <= 16'd0;
      oe      <= 1'b0;
      busy    <= 1'b0;
      wr_en   <= 1'b0;
      wr_data <= 8'd0;
      rd_en   <= 1'b0;
      rd_cap  <= 1'b0;
      rd_wait <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      rw      <= rw_n;
      addr    <= addr_n;
      oe      <= oe_n;
      busy    <= busy_n;
      wr_en   <= wr_en_n;
      wr_data <= wr_data_n;
      rd_en   <= rd_en_n;
      rd_cap  <= rd_cap_n;
      rd_wait <= rd_wait_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    rw_n      = rw;
    addr_n    = addr;
    oe_n      = oe;
    busy_n    = busy;
    wr_en_n   = 1'b0;
    wr_data_n = wr_data;
    rd_en_n   = 1'b0;
    rd_cap_n  = rd_en;
    rd_wait_n = rd_wait;

    // Post-write increment lands one cycle after the strobe.
    if (wr_en) addr_n = addr + 16'd1;

    if (!iEn) begin
      state_n   = S_IDLE;
      oe_n      = 1'b0;
      busy_n    = 1'b0;
      bit_cnt_n = 4'd0;
      rd_cap_n  = 1'b0;
      rd_wait_n = 1'b0;
    end else if (start_det) begin
      state_n   = S_DEV_ADDR;
      bit_cnt_n = 4'd0;
      oe_n      = 1'b0;
      busy_n    = 1'b1;
      rd_cap_n  = 1'b0;
      rd_wait_n = 1'b0;
    end else if (stop_det) begin
      state_n   = S_IDLE;
      bit_cnt_n = 4'd0;
      oe_n      = 1'b0;
      busy_n    = 1'b0;
      rd_cap_n  = 1'b0;
      rd_wait_n = 1'b0;
    end else begin
      case (state)
        S_DEV_ADDR, S_SUB_HI, S_SUB_LO, S_WR_DATA: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            shreg_n   = shift_in;
            bit_cnt_n = bit_cnt + 4'd1;
            if (state == S_DEV_ADDR && bit_cnt == 4'd7 && shift_in[7:1] != SLAVE_ID)
              state_n = S_IGNORE;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            bit_cnt_n = 4'd0;
            oe_n      = 1'b1;
            case (state)
              S_DEV_ADDR: begin
                rw_n    = shreg[0];
                state_n = S_ACK_DEV;
              end
              S_SUB_HI: begin
                addr_n[15:8] = shreg;
                state_n      = S_ACK_HI;
              end
              S_SUB_LO: begin
                addr_n[7:0] = shreg;
                state_n     = S_ACK_LO;
              end
              default: begin
                wr_en_n   = 1'b1;
                wr_data_n = shreg;
                state_n   = S_ACK_WR;
              end
            endcase
          end
        end
        S_ACK_DEV: begin
          if (scl_fall) begin
            oe_n      = 1'b0;
            bit_cnt_n = 4'd0;
            if (rw) begin
              state_n   = S_RD_DATA;
              rd_en_n   = 1'b1;
              rd_wait_n = 1'b0;
            end else begin
              state_n = S_SUB_HI;
            end
          end
        end
        S_ACK_HI: if (scl_fall) begin oe_n = 1'b0; state_n = S_SUB_LO; end
        S_ACK_LO: if (scl_fall) begin oe_n = 1'b0; state_n = S_WR_DATA; end
        S_ACK_WR: if (scl_fall) begin oe_n = 1'b0; state_n = S_WR_DATA; end
        S_RD_DATA: begin
          // First byte is loaded while SCL is low after the ACK fall; later bytes wait for the fall.
          if (rd_cap) begin
            shreg_n = iRegRdData;
            if (!rd_wait) oe_n = ~iRegRdData[7];
          end else if (scl_fall) begin
            if (rd_wait) begin
              oe_n      = ~shreg[7];
              rd_wait_n = 1'b0;
              bit_cnt_n = 4'd0;
            end else if (bit_cnt == 4'd7) begin
              oe_n      = 1'b0;
              bit_cnt_n = 4'd0;
              state_n   = S_RD_MACK;
            end else begin
              shreg_n   = {shreg[6:0], 1'b1};
              oe_n      = ~shreg[6];
              bit_cnt_n = bit_cnt + 4'd1;
            end
          end
        end
        S_RD_MACK: begin
          if (scl_rise) begin
            addr_n = addr + 16'd1;
            if (sda) begin
              state_n = S_IGNORE;
            end else begin
              rd_en_n   = 1'b1;
              rd_wait_n = 1'b1;
              bit_cnt_n = 4'd0;
              state_n   = S_RD_DATA;
            end
          end
        end
        default: oe_n = 1'b0;
      endcase
    end
  end

  assign oSDA_OE    = oe;
  assign oRegAddr   = addr;
  assign oRegWrEn   = wr_en;
  assign oRegWrData = wr_data;
  assign oRegRdEn   = rd_en;
  assign oBusy      = busy;

endmodule

// File: tb/tb_zov5640_sccb_slave.sv
// tb/tb_zov5640_sccb_slave.sv - bus-master bench with strobe scoreboard for zov5640_sccb_slave
module tb_zov5640_sccb_slave;

  localparam int Q = 10;

  logic        clk = 1'b0;
  logic        rstn, en, scl, sda_m;
  logic        oe, wr_en, rd_en, busy;
  logic [15:0] addr;
  logic [7:0]  wr_data, rd_data;
  wire         sda_line = sda_m & ~oe;

  int vectors = 0, miscompares = 0;
  int oe_cnt = 0, wr_cnt = 0, rd_cnt = 0;

  typedef struct packed { logic [15:0] a; logic [7:0] d; } wr_t;
  wr_t         exp_wr[$];
  logic [15:0] exp_rd[$];
  wr_t         e_wr;
  logic [15:0] e_rd;

  always #5 clk = ~clk;

  zov5640_sccb_slave #(.SLAVE_ID(7'h3C), .SYNC_STG(2)) dut (
    .iClk(clk), .iRstN(rstn), .iEn(en), .iSCL(scl), .iSDA(sda_line),
    .oSDA_OE(oe), .oRegAddr(addr), .oRegWrEn(wr_en), .oRegWrData(wr_data),
    .oRegRdEn(rd_en), .iRegRdData(rd_data), .oBusy(busy)
  );

  function automatic logic [7:0] rd_model(input logic [15:0] a);
    return a[7:0] ^ 8'h5C;
  endfunction

  // Registered register-file model: data valid the cycle after the request.
  always @(posedge clk) if (rd_en) rd_data <= rd_model(addr);

  always @(negedge clk) begin
    if (oe) oe_cnt++;
    if (wr_en) begin
      wr_cnt++;
      vectors++;
      if (exp_wr.size() == 0) begin
        miscompares++;
        $display("FAIL wr_strobe: unexpected addr=%h data=%h", addr, wr_data);
      end else begin
        e_wr = exp_wr.pop_front();
        if ({addr, wr_data} !== {e_wr.a, e_wr.d}) begin
          miscompares++;
          $display("FAIL wr_strobe: got addr=%h data=%h, expected addr=%h data=%h", addr, wr_data, e_wr.a, e_wr.d);
        end
      end
    end
    if (rd_en) begin
      rd_cnt++;
      vectors++;
      if (exp_rd.size() == 0) begin
        miscompares++;
        $display("FAIL rd_strobe: unexpected addr=%h", addr);
      end else begin
        e_rd = exp_rd.pop_front();
        if (addr !== e_rd) begin
          miscompares++;
          $display("FAIL rd_strobe: got addr=%h, expected %h", addr, e_rd);
        end
      end
    end
  end

  task automatic wait_q();
    repeat (Q) @(posedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; scl = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_q();
    scl = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; wait_q();
    scl = 1'b1; wait_q(); wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_q();
    scl = 1'b1; wait_q();
    @(negedge clk) b = sda_line;
    wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic mack);
    logic t;
    for (int i = 7; i >= 0; i--) begin
      read_bit(t);
      d[i] = t;
    end
    write_bit(mack);
  endtask

  task automatic send_bytes(input string name, input logic [7:0] b[], input logic exp_ack);
    logic ack;
    foreach (b[i]) begin
      write_byte(b[i], ack);
      vectors++;
      if (ack !== exp_ack) begin
        miscompares++;
        $display("FAIL %s ack[%0d]: got %b expected %b", name, i, ack, exp_ack);
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; en = 1'b1; scl = 1'b1; sda_m = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({oe, addr, wr_en, wr_data, rd_en, busy} !== 28'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got oe=%b addr=%h we=%b wd=%h re=%b busy=%b, expected all 0", oe, addr, wr_en, wr_data, rd_en, busy);
    end
    rstn = 1'b1;
    wait_q();
  endtask

  task automatic test_write_single();
    int w0 = wr_cnt;
    exp_wr.push_back('{16'h3008, 8'h82});
    bus_start();
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b expected 1", busy); end
    send_bytes("single", '{8'h78, 8'h30, 8'h08, 8'h82}, 1'b0);
    bus_stop();
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_clr: got %b expected 0", busy); end
    vectors++;
    if (wr_cnt - w0 !== 1) begin miscompares++; $display("FAIL single_wr_count: got %0d expected 1", wr_cnt - w0); end
    vectors++;
    if (addr !== 16'h3009) begin miscompares++; $display("FAIL single_addr_inc: got %h expected 3009", addr); end
  endtask

  task automatic test_write_read();
    logic       ack;
    logic [7:0] d;
    int w0 = wr_cnt, r0 = rd_cnt;
    bus_start();
    send_bytes("setaddr", '{8'h78, 8'h30, 8'h0A}, 1'b0);
    bus_stop();
    vectors++;
    if (addr !== 16'h300A) begin miscompares++; $display("FAIL setaddr_addr: got %h expected 300a", addr); end
    exp_rd.push_back(16'h300A);
    bus_start();
    write_byte(8'h79, ack);
    vectors++;
    if (ack !== 1'b0) begin miscompares++; $display("FAIL read_id_ack: got %b expected 0", ack); end
    read_byte(d, 1'b1);
    vectors++;
    if (d !== rd_model(16'h300A)) begin miscompares++; $display("FAIL read_data: got %h expected %h", d, rd_model(16'h300A)); end
    bus_stop();
    vectors++;
    if (addr !== 16'h300B) begin miscompares++; $display("FAIL read_addr_inc: got %h expected 300b", addr); end
    vectors++;
    if (rd_cnt - r0 !== 1 || wr_cnt - w0 !== 0) begin
      miscompares++;
      $display("FAIL read_strobe_count: got rd=%0d wr=%0d expected rd=1 wr=0", rd_cnt - r0, wr_cnt - w0);
    end
  endtask

  task automatic test_bad_id();
    int o0 = oe_cnt, w0 = wr_cnt, r0 = rd_cnt;
    bus_start();
    send_bytes("bad_id", '{8'h84, 8'h30}, 1'b1);
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL bad_id_busy: got %b expected 1", busy); end
    bus_stop();
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL bad_id_busy_clr: got %b expected 0", busy); end
    vectors++;
    if (oe_cnt - o0 !== 0 || wr_cnt - w0 !== 0 || rd_cnt - r0 !== 0) begin
      miscompares++;
      $display("FAIL bad_id_quiet: got oe_cycles=%0d wr=%0d rd=%0d expected 0 0 0", oe_cnt - o0, wr_cnt - w0, rd_cnt - r0);
    end
  endtask

  task automatic test_burst_wrap();
    int w0 = wr_cnt;
    exp_wr.push_back('{16'hFFFF, 8'h11});
    exp_wr.push_back('{16'h0000, 8'h22});
    bus_start();
    send_bytes("burst", '{8'h78, 8'hFF, 8'hFF, 8'h11, 8'h22}, 1'b0);
    bus_stop();
    vectors++;
    if (wr_cnt - w0 !== 2) begin miscompares++; $display("FAIL burst_count: got %0d expected 2", wr_cnt - w0); end
    vectors++;
    if (addr !== 16'h0001) begin miscompares++; $display("FAIL burst_addr: got %h expected 0001", addr); end
  endtask

  task automatic test_partial_stop();
    logic [3:0] nib = 4'hA;
    int w0 = wr_cnt;
    bus_start();
    send_bytes("partial", '{8'h78, 8'h30, 8'h08}, 1'b0);
    for (int i = 3; i >= 0; i--) write_bit(nib[i]);
    bus_stop();
    vectors++;
    if (busy !== 1'b0 || oe !== 1'b0) begin miscompares++; $display("FAIL partial_idle: got busy=%b oe=%b expected 0 0", busy, oe); end
    vectors++;
    if (wr_cnt - w0 !== 0) begin miscompares++; $display("FAIL partial_no_strobe: got %0d expected 0", wr_cnt - w0); end
  endtask

  task automatic test_reset_mid_read();
    logic       ack, t;
    logic [3:0] hi;
    logic [7:0] exp_d = rd_model(16'h3008);
    int o0;
    exp_rd.push_back(16'h3008);
    bus_start();
    write_byte(8'h79, ack);
    vectors++;
    if (ack !== 1'b0) begin miscompares++; $display("FAIL rst_read_ack: got %b expected 0", ack); end
    for (int i = 3; i >= 0; i--) begin
      read_bit(t);
      hi[i] = t;
    end
    vectors++;
    if (hi !== exp_d[7:4]) begin miscompares++; $display("FAIL rst_read_hi: got %h expected %h", hi, exp_d[7:4]); end
    vectors++;
    if (oe !== ~exp_d[3]) begin miscompares++; $display("FAIL rst_read_bit3_drive: got %b expected %b", oe, ~exp_d[3]); end
    @(negedge clk) rstn = 1'b0;
    @(negedge clk);
    vectors++;
    if ({oe, addr, wr_en, wr_data, rd_en, busy} !== 28'd0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: got oe=%b addr=%h we=%b wd=%h re=%b busy=%b, expected all 0", oe, addr, wr_en, wr_data, rd_en, busy);
    end
    rstn = 1'b1;
    o0 = oe_cnt;
    for (int i = 0; i < 4; i++) read_bit(t);
    write_bit(1'b1);
    bus_stop();
    vectors++;
    if (oe_cnt - o0 !== 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_quiet: got oe_cycles=%0d busy=%b expected 0 0", oe_cnt - o0, busy);
    end
    exp_wr.push_back('{16'h1234, 8'hAB});
    bus_start();
    send_bytes("post_rst", '{8'h78, 8'h12, 8'h34, 8'hAB}, 1'b0);
    bus_stop();
    vectors++;
    if (addr !== 16'h1235) begin miscompares++; $display("FAIL post_rst_addr: got %h expected 1235", addr); end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rd_data = 8'h00;
    test_reset();
    test_write_single();
    test_write_read();
    test_bad_id();
    test_burst_wrap();
    test_partial_stop();
    test_reset_mid_read();
    wait_q();
    vectors++;
    if (exp_wr.size() != 0 || exp_rd.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got wr=%0d rd=%0d pending, expected 0 0", exp_wr.size(), exp_rd.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
